// File: rtl/cv_pad_pkg.sv
// Shared ColecoVision controller definitions: keypad pin codes, joystick vector
// bit positions and the pad reader scan states.
package cv_pad_pkg;

  // Keypad codes as seen on {P1,P2,P3,P4} while the keypad select is low.
  localparam logic [3:0] CV_KEY_0      = 4'b0011;
  localparam logic [3:0] CV_KEY_1      = 4'b1110;
  localparam logic [3:0] CV_KEY_2      = 4'b1101;
  localparam logic [3:0] CV_KEY_3      = 4'b0110;
  localparam logic [3:0] CV_KEY_4      = 4'b0001;
  localparam logic [3:0] CV_KEY_5      = 4'b1001;
  localparam logic [3:0] CV_KEY_6      = 4'b0111;
  localparam logic [3:0] CV_KEY_7      = 4'b1100;
  localparam logic [3:0] CV_KEY_8      = 4'b1000;
  localparam logic [3:0] CV_KEY_9      = 4'b1011;
  localparam logic [3:0] CV_KEY_STAR   = 4'b1010;
  localparam logic [3:0] CV_KEY_HASH   = 4'b0101;
  localparam logic [3:0] CV_KEY_PURPLE = 4'b0100;
  localparam logic [3:0] CV_KEY_BLUE   = 4'b0010;
  localparam logic [3:0] CV_KEY_NONE   = 4'b1111;

  localparam logic [9:0][3:0] CV_KEY_DIGITS = {
    CV_KEY_9, CV_KEY_8, CV_KEY_7, CV_KEY_6, CV_KEY_5,
    CV_KEY_4, CV_KEY_3, CV_KEY_2, CV_KEY_1, CV_KEY_0
  };

  localparam int JOY_RIGHT  = 0;
  localparam int JOY_LEFT   = 1;
  localparam int JOY_DOWN   = 2;
  localparam int JOY_UP     = 3;
  localparam int JOY_FIRE1  = 4;
  localparam int JOY_FIRE2  = 5;
  localparam int JOY_STAR   = 6;
  localparam int JOY_HASH   = 7;
  localparam int JOY_KEY0   = 8;
  localparam int JOY_PURPLE = 18;
  localparam int JOY_BLUE   = 19;
  localparam int JOY_W      = 20;

  typedef enum logic [2:0] {
    ST_JS_SETTLE,
    ST_JS_SAMPLE,
    ST_KP_SETTLE,
    ST_KP_SAMPLE,
    ST_COMMIT
  } pad_state_e;

endpackage

// File: rtl/cv_key_decode.sv
// Keypad code to one-hot joystick-vector field; only bits [19:6] can be set,
// unknown codes (including 0000 and 1111) yield an all-zero field.
module cv_key_decode
  import cv_pad_pkg::*;
(
  input  logic [3:0]       code_i,
  output logic [JOY_W-1:0] key_o
);

  assign key_o[JOY_STAR-1:0] = '0;
  assign key_o[JOY_STAR]     = (code_i == CV_KEY_STAR);
  assign key_o[JOY_HASH]     = (code_i == CV_KEY_HASH);
  assign key_o[JOY_PURPLE]   = (code_i == CV_KEY_PURPLE);
  assign key_o[JOY_BLUE]     = (code_i == CV_KEY_BLUE);

  generate
    for (genvar gi = 0; gi < 10; gi++) begin : g_digit
      assign key_o[JOY_KEY0+gi] = (code_i == CV_KEY_DIGITS[gi]);
    end
  endgenerate

endmodule

// File: rtl/cv_pad_reader.sv
// Scans a ColecoVision controller in joystick then keypad mode, debounces
// whole scans and publishes the decoded 20-bit joystick vector.
module cv_pad_reader
  import cv_pad_pkg::*;
#(
  parameter int SETTLE   = 8,
  parameter int DEBOUNCE = 3
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             clk_en_i,
  input  logic [4:0]       pin_i,
  output logic             sel_js_n_o,
  output logic             sel_kp_n_o,
  output logic [JOY_W-1:0] joy_o,
  output logic             upd_o
);

  localparam int SW = $clog2(SETTLE);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [3:0]    DEB_MIN     = 4'(DEBOUNCE);

  logic [4:0]       sync1_q, sync2_q;
  pad_state_e       state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [JOY_W-1:0] scan_q, scan_d;
  logic [JOY_W-1:0] cand_q, cand_d;
  logic [JOY_W-1:0] joy_q, joy_d;
  logic [JOY_W-1:0] key_field;
  logic [3:0]       cnt_q, cnt_d;
  logic             upd_q, upd_d;

  // Synchronizer runs every clk so pin edges are never missed while gated.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

  cv_key_decode u_key_decode (
    .code_i (sync2_q[3:0]),
    .key_o  (key_field)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q  <= ST_JS_SETTLE;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    if (clk_en_i) begin
      case (state_q)
        ST_JS_SETTLE, ST_KP_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            settle_d = '0;
            state_d  = (state_q == ST_JS_SETTLE) ? ST_JS_SAMPLE : ST_KP_SAMPLE;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
        ST_JS_SAMPLE: state_d = ST_KP_SETTLE;
        ST_KP_SAMPLE: state_d = ST_COMMIT;
        default:      state_d = ST_JS_SETTLE;
      endcase
    end
  end

  // Settle count 0 is the break-before-make cycle with both selects released.
  always_comb begin
    sel_js_n_o = 1'b1;
    sel_kp_n_o = 1'b1;
    case (state_q)
      ST_JS_SETTLE: sel_js_n_o = (settle_q == '0);
      ST_JS_SAMPLE: sel_js_n_o = 1'b0;
      ST_KP_SETTLE: sel_kp_n_o = (settle_q == '0);
      ST_KP_SAMPLE: sel_kp_n_o = 1'b0;
      ST_COMMIT:    sel_kp_n_o = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    scan_d = scan_q;
    cand_d = cand_q;
    cnt_d  = cnt_q;
    joy_d  = joy_q;
    upd_d  = 1'b0;
    if (clk_en_i) begin
      case (state_q)
        ST_JS_SAMPLE: begin
          scan_d[JOY_UP:JOY_RIGHT] = ~sync2_q[3:0];
          scan_d[JOY_FIRE1]        = ~sync2_q[4];
        end
        ST_KP_SAMPLE: begin
          scan_d = key_field | {14'd0, ~sync2_q[4], scan_q[JOY_FIRE1:0]};
        end
        ST_COMMIT: begin
          if (scan_q == cand_q) begin
            if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
          end else begin
            cand_d = scan_q;
            cnt_d  = 4'd1;
          end
          if ((cnt_d >= DEB_MIN) && (cand_d != joy_q)) begin
            joy_d = cand_d;
            upd_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      scan_q <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
      joy_q  <= '0;
      upd_q  <= 1'b0;
    end else begin
      scan_q <= scan_d;
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      joy_q  <= joy_d;
      upd_q  <= upd_d;
    end
  end

  assign joy_o = joy_q;
  assign upd_o = upd_q;

endmodule
